// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants and state type for the servo SPI link
// Purpose: link bytes, opcodes, disc/tray codes and FSM state encoding.
// Ports: none (package).
package servo_pkg;

  localparam logic [7:0] SERVO_SYNC     = 8'hDD;
  localparam logic [7:0] SERVO_SYNC_ACK = 8'hEE;
  localparam logic [7:0] SERVO_CMD_ACK  = 8'h55;
  localparam logic [7:0] SERVO_POLL     = 8'hAA;
  localparam logic [7:0] SERVO_HDR0     = 8'h03;
  localparam logic [7:0] SERVO_HDR1     = 8'hB0;
  localparam logic [7:0] SERVO_FILL     = 8'h00;
  localparam logic [7:0] SERVO_IDLE     = 8'hFF;

  localparam logic [7:0] OP_STATUS = 8'hB0;
  localparam logic [7:0] OP_OPEN   = 8'hA6;
  localparam logic [7:0] OP_CLOSE  = 8'hA7;

  localparam logic [7:0] DISC_AUDIO  = 8'h01;
  localparam logic [7:0] DISC_NONE   = 8'h03;
  localparam logic [7:0] DISC_CDI    = 8'h04;
  localparam logic [7:0] TRAY_CLOSED = 8'h25;
  localparam logic [7:0] TRAY_OPEN   = 8'h21;

  typedef enum logic [2:0] {
    ST_SYNC       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_CMD_SEND   = 3'd2,
    ST_WAIT_FAULT = 3'd3,
    ST_STAT_READ  = 3'd4
  } servo_state_e;

endpackage

// File: rtl/parallelel_spi.sv
// rtl/parallelel_spi.sv - byte-parallel SPI link bundle between initiator and servo
// Purpose: write strobe with mosi byte out, combinational miso byte back.
// Ports: write (1-cycle strobe), mosi[7:0], miso[7:0]; master/slave modports.
interface parallelel_spi;
  logic       write;
  logic [7:0] mosi;
  logic [7:0] miso;

  modport master (output write, output mosi, input miso);
  modport slave  (input write, input mosi, output miso);
endinterface

// File: rtl/servo_byte_pacer.sv
// rtl/servo_byte_pacer.sv - inter-byte gap down-counter for the servo link strobes
// Purpose: fire once every BYTE_GAP+1 cycles; start reloads so the first fire
//          after start is BYTE_GAP cycles later (strobe registered one cycle after).
// Ports: clk, reset_n (async active-low), start (reload), fire (gap elapsed).
module servo_byte_pacer #(
  parameter int BYTE_GAP = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic fire
);

  localparam int CW = (BYTE_GAP < 1) ? 1 : $clog2(BYTE_GAP + 1);
  localparam logic [CW-1:0] RELOAD = CW'(BYTE_GAP);

  logic [CW-1:0] cnt;

  assign fire = (cnt == '0);

  // Reset loads the full gap so the first SYNC strobe lands at cycle BYTE_GAP+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RELOAD;
    end else if (start || fire) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/servo_link_master.sv
// rtl/servo_link_master.sv - initiator side of the byte-parallel servo SPI link
// Purpose: link sync, command transfer with response capture, and reading the
//          5-byte disc-status frame after a command or a responder mode fault.
// Ports: clk, reset_n (async active-low), spi (master modport), mode_fault,
//        req_valid/req_ready/req_opcode/req_arg_len (command in),
//        rsp_valid/rsp_ack_ok/rsp_data (command response),
//        status_valid/status_disc/status_tray (disc state), link_up, error.
module servo_link_master
  import servo_pkg::*;
#(
  parameter int BYTE_GAP       = 16,
  parameter int STATUS_TIMEOUT = 4095
) (
  input  logic                clk,
  input  logic                reset_n,
  parallelel_spi.master       spi,
  input  logic                mode_fault,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [7:0]          req_opcode,
  input  logic [1:0]          req_arg_len,
  output logic                rsp_valid,
  output logic                rsp_ack_ok,
  output logic [23:0]         rsp_data,
  output logic                status_valid,
  output logic [7:0]          status_disc,
  output logic [7:0]          status_tray,
  output logic                link_up,
  output logic                error
);

  localparam int TW = $clog2(STATUS_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(STATUS_TIMEOUT);

  servo_state_e  state;
  logic [7:0]    opcode_q;
  logic [1:0]    arg_len_q;
  logic [2:0]    byte_idx;
  logic [TW-1:0] wait_cnt;
  logic          hdr_bad;
  logic [7:0]    disc_stage;
  logic          pace_start;
  logic          pace_fire;

  // mode_fault has priority over a request in the same IDLE cycle.
  assign req_ready = (state == ST_IDLE) && link_up && !mode_fault;

  // Reload the pacer on every entry into a strobing state.
  assign pace_start = ((state == ST_IDLE) && (mode_fault || req_valid))
                    || ((state == ST_WAIT_FAULT) && mode_fault);

  servo_byte_pacer #(.BYTE_GAP(BYTE_GAP)) u_pacer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (pace_start),
    .fire    (pace_fire)
  );

  // miso is evaluated in the strobe cycle (spi.write high); the next strobe
  // is only launched on a later pacer fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_SYNC;
      spi.write    <= 1'b0;
      spi.mosi     <= SERVO_IDLE;
      rsp_valid    <= 1'b0;
      rsp_ack_ok   <= 1'b0;
      rsp_data     <= '0;
      status_valid <= 1'b0;
      status_disc  <= DISC_NONE;
      status_tray  <= TRAY_CLOSED;
      link_up      <= 1'b0;
      error        <= 1'b0;
      opcode_q     <= '0;
      arg_len_q    <= '0;
      byte_idx     <= '0;
      wait_cnt     <= '0;
      hdr_bad      <= 1'b0;
      disc_stage   <= DISC_NONE;
    end else begin
      spi.write    <= 1'b0;
      spi.mosi     <= SERVO_IDLE;
      rsp_valid    <= 1'b0;
      status_valid <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (spi.write && (spi.miso == SERVO_SYNC_ACK)) begin
            link_up <= 1'b1;
            state   <= ST_IDLE;
          end else if (pace_fire) begin
            spi.write <= 1'b1;
            spi.mosi  <= SERVO_SYNC;
          end
        end
        ST_IDLE: begin
          if (mode_fault) begin
            byte_idx <= '0;
            hdr_bad  <= 1'b0;
            state    <= ST_STAT_READ;
          end else if (req_valid && req_ready) begin
            opcode_q   <= req_opcode;
            arg_len_q  <= req_arg_len;
            byte_idx   <= '0;
            rsp_data   <= '0;
            rsp_ack_ok <= 1'b0;
            state      <= ST_CMD_SEND;
          end
        end
        ST_CMD_SEND: begin
          if (spi.write) begin
            case (byte_idx)
              3'd0:    rsp_ack_ok      <= (spi.miso == SERVO_CMD_ACK);
              3'd1:    rsp_data[23:16] <= spi.miso;
              3'd2:    rsp_data[15:8]  <= spi.miso;
              default: rsp_data[7:0]   <= spi.miso;
            endcase
            if (byte_idx == {1'b0, arg_len_q}) begin
              rsp_valid <= 1'b1;
              wait_cnt  <= '0;
              state     <= ST_WAIT_FAULT;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end else if (pace_fire) begin
            spi.write <= 1'b1;
            spi.mosi  <= (byte_idx == 3'd0) ? opcode_q : SERVO_FILL;
          end
        end
        ST_WAIT_FAULT: begin
          if (mode_fault) begin
            byte_idx <= '0;
            hdr_bad  <= 1'b0;
            state    <= ST_STAT_READ;
          end else if (wait_cnt == TIMEOUT_VAL) begin
            error <= 1'b1;
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_STAT_READ: begin
          if (spi.write) begin
            byte_idx <= byte_idx + 3'd1;
            case (byte_idx)
              3'd0: if (spi.miso != SERVO_HDR0) hdr_bad <= 1'b1;
              3'd1: if (spi.miso != SERVO_HDR1) hdr_bad <= 1'b1;
              3'd2: if (spi.miso != SERVO_FILL) hdr_bad <= 1'b1;
              3'd3: disc_stage <= spi.miso;
              default: begin
                // The whole frame is always clocked out so the responder stays
                // aligned; a bad header only suppresses the update.
                if (hdr_bad) begin
                  error <= 1'b1;
                end else begin
                  status_disc  <= disc_stage;
                  status_tray  <= spi.miso;
                  status_valid <= 1'b1;
                end
                state <= ST_IDLE;
              end
            endcase
          end else if (pace_fire) begin
            spi.write <= 1'b1;
            spi.mosi  <= SERVO_POLL;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_link_master.sv
// tb/tb_servo_link_master.sv - directed self-checking bench for servo_link_master
// Purpose: drives the responder side of the link and the command port, checks
//          sync, commands, status frames, header error, timeout and mid-read reset.
// Ports: none (top-level bench).
module tb_servo_link_master;

  localparam int BYTE_GAP       = 2;
  localparam int STATUS_TIMEOUT = 30;

  logic        clk;
  logic        reset_n;
  logic        mode_fault;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_opcode;
  logic [1:0]  req_arg_len;
  logic        rsp_valid;
  logic        rsp_ack_ok;
  logic [23:0] rsp_data;
  logic        status_valid;
  logic [7:0]  status_disc;
  logic [7:0]  status_tray;
  logic        link_up;
  logic        error;

  parallelel_spi spi_if ();

  servo_link_master #(
    .BYTE_GAP       (BYTE_GAP),
    .STATUS_TIMEOUT (STATUS_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi          (spi_if),
    .mode_fault   (mode_fault),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_arg_len  (req_arg_len),
    .rsp_valid    (rsp_valid),
    .rsp_ack_ok   (rsp_ack_ok),
    .rsp_data     (rsp_data),
    .status_valid (status_valid),
    .status_disc  (status_disc),
    .status_tray  (status_tray),
    .link_up      (link_up),
    .error        (error)
  );

  int checks   = 0;
  int failures = 0;
  int cyc;
  int this_strobe;
  int prev_strobe;
  int accept_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_strobe();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (spi_if.write) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("strobe_seen", {31'd0, ok}, 32'd1);
    prev_strobe = this_strobe;
    this_strobe = cyc;
  endtask

  // Answer one strobe with resp and check the byte the master sent.
  task automatic xfer(input logic [7:0] resp, input logic [7:0] exp_mosi, input string tag);
    wait_strobe();
    check_eq(tag, {24'd0, spi_if.mosi}, {24'd0, exp_mosi});
    spi_if.miso = resp;
    @(negedge clk);
    spi_if.miso = 8'hFF;
  endtask

  task automatic frame(input logic [39:0] bytes);
    for (int i = 0; i < 5; i++) begin
      xfer(bytes[39-8*i -: 8], 8'hAA, "stat_mosi");
    end
  endtask

  task automatic send_req(input logic [7:0] op, input logic [1:0] len);
    check_eq("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_opcode  = op;
    req_arg_len = len;
    accept_cyc  = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic pulse_fault();
    mode_fault = 1'b1;
    @(negedge clk);
    mode_fault = 1'b0;
  endtask

  initial begin
    int n;
    reset_n      = 1'b0;
    mode_fault   = 1'b0;
    req_valid    = 1'b0;
    req_opcode   = 8'h00;
    req_arg_len  = 2'd0;
    spi_if.miso  = 8'hFF;
    this_strobe  = 0;
    prev_strobe  = 0;
    accept_cyc   = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_write", {31'd0, spi_if.write}, 32'd0);
    check_eq("rst_mosi", {24'd0, spi_if.mosi}, 32'hFF);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_link", {31'd0, link_up}, 32'd0);
    check_eq("rst_err", {31'd0, error}, 32'd0);
    check_eq("rst_disc", {24'd0, status_disc}, 32'h03);
    check_eq("rst_tray", {24'd0, status_tray}, 32'h25);
    check_eq("rst_data", {8'd0, rsp_data}, 32'd0);
    reset_n = 1'b1;

    // Sync: three unanswered DD strobes, then EE
    xfer(8'hFF, 8'hDD, "sync_mosi");
    check_eq("sync_first_cyc", this_strobe, BYTE_GAP + 1);
    xfer(8'hFF, 8'hDD, "sync_mosi");
    check_eq("sync_gap", this_strobe - prev_strobe, BYTE_GAP + 1);
    check_eq("link_early", {31'd0, link_up}, 32'd0);
    xfer(8'hFF, 8'hDD, "sync_mosi");
    xfer(8'hEE, 8'hDD, "sync_mosi");
    check_eq("link_up", {31'd0, link_up}, 32'd1);
    check_eq("ready_up", {31'd0, req_ready}, 32'd1);

    // Status command with three fillers, then a good frame
    send_req(8'hB0, 2'd3);
    xfer(8'h55, 8'hB0, "cmd_op_mosi");
    check_eq("cmd_first_cyc", this_strobe, accept_cyc + BYTE_GAP + 1);
    xfer(8'h61, 8'h00, "cmd_fill_mosi");
    check_eq("cmd_gap", this_strobe - prev_strobe, BYTE_GAP + 1);
    xfer(8'h01, 8'h00, "cmd_fill_mosi");
    check_eq("rsp_early", {31'd0, rsp_valid}, 32'd0);
    xfer(8'h01, 8'h00, "cmd_fill_mosi");
    check_eq("b0_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("b0_ack", {31'd0, rsp_ack_ok}, 32'd1);
    check_eq("b0_data", {8'd0, rsp_data}, 32'h610101);
    pulse_fault();
    frame(40'h03_B0_00_04_25);
    check_eq("b0_stat_valid", {31'd0, status_valid}, 32'd1);
    check_eq("b0_disc", {24'd0, status_disc}, 32'h04);
    check_eq("b0_tray", {24'd0, status_tray}, 32'h25);
    check_eq("b0_err", {31'd0, error}, 32'd0);
    @(negedge clk);
    check_eq("stat_pulse_1cyc", {31'd0, status_valid}, 32'd0);

    // Open command, responder does not ack
    send_req(8'hA6, 2'd3);
    xfer(8'h00, 8'hA6, "cmd_op_mosi");
    xfer(8'h00, 8'h00, "cmd_fill_mosi");
    xfer(8'h00, 8'h00, "cmd_fill_mosi");
    xfer(8'h00, 8'h00, "cmd_fill_mosi");
    check_eq("a6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("a6_ack", {31'd0, rsp_ack_ok}, 32'd0);
    check_eq("a6_data", {8'd0, rsp_data}, 32'd0);
    pulse_fault();
    frame(40'h03_B0_00_03_21);
    check_eq("a6_stat_valid", {31'd0, status_valid}, 32'd1);
    check_eq("a6_disc", {24'd0, status_disc}, 32'h03);
    check_eq("a6_tray", {24'd0, status_tray}, 32'h21);
    check_eq("a6_err", {31'd0, error}, 32'd0);

    // mode_fault and req_valid together: status read wins, command follows
    mode_fault  = 1'b1;
    req_valid   = 1'b1;
    req_opcode  = 8'hA7;
    req_arg_len = 2'd0;
    #1;
    check_eq("both_ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    mode_fault = 1'b0;
    frame(40'h03_B0_00_01_25);
    check_eq("both_stat_valid", {31'd0, status_valid}, 32'd1);
    check_eq("both_disc", {24'd0, status_disc}, 32'h01);
    check_eq("both_ready_after", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    xfer(8'h55, 8'hA7, "a7_op_mosi");
    check_eq("a7_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("a7_ack", {31'd0, rsp_ack_ok}, 32'd1);
    check_eq("a7_data", {8'd0, rsp_data}, 32'd0);

    // Bad header byte 1
    pulse_fault();
    frame(40'h03_B1_00_04_25);
    check_eq("bad_stat_valid", {31'd0, status_valid}, 32'd0);
    check_eq("bad_err", {31'd0, error}, 32'd1);
    check_eq("bad_disc_kept", {24'd0, status_disc}, 32'h01);

    // Reset during the 3rd status strobe
    send_req(8'hB0, 2'd0);
    xfer(8'h55, 8'hB0, "cmd_op_mosi");
    pulse_fault();
    xfer(8'h03, 8'hAA, "stat_mosi");
    xfer(8'hB0, 8'hAA, "stat_mosi");
    wait_strobe();
    reset_n = 1'b0;
    #1;
    check_eq("mid_write", {31'd0, spi_if.write}, 32'd0);
    check_eq("mid_mosi", {24'd0, spi_if.mosi}, 32'hFF);
    check_eq("mid_err", {31'd0, error}, 32'd0);
    check_eq("mid_link", {31'd0, link_up}, 32'd0);
    check_eq("mid_ready", {31'd0, req_ready}, 32'd0);
    check_eq("mid_disc", {24'd0, status_disc}, 32'h03);
    check_eq("mid_tray", {24'd0, status_tray}, 32'h25);
    @(negedge clk);
    reset_n = 1'b1;
    xfer(8'hEE, 8'hDD, "resync_mosi");
    check_eq("resync_cyc", this_strobe, BYTE_GAP + 1);
    check_eq("resync_link", {31'd0, link_up}, 32'd1);

    // Command with no mode_fault: timeout
    send_req(8'hA6, 2'd0);
    xfer(8'h55, 8'hA6, "cmd_op_mosi");
    check_eq("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (error) begin
        n = i;
        break;
      end
    end
    check_eq("to_cycles", n, STATUS_TIMEOUT + 1);
    check_eq("to_err", {31'd0, error}, 32'd1);
    check_eq("to_idle_ready", {31'd0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_link_master.md
# servo_link_master

Initiator side of the byte-parallel servo SPI link. It drives the `parallelel_spi` master modport toward the servo responder and runs the full exchange sequence: link sync, command transfer, and collection of the unsolicited 5-byte disc-status frame. The status frame is read after a command or after a responder-raised mode fault. It sits between the CD subsystem controller (command requester) and the servo model. It exposes the decoded disc state word and tray state to the rest of the design.

## Interface
Parameters:
- BYTE_GAP, 16: idle cycles between consecutive `spi.write` strobes (min 1).
- STATUS_TIMEOUT, 4095: cycles to wait for mode fault before a status frame is declared missing.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- spi  master modport  –  `parallelel_spi` master modport:
  - `write`: output, 1-cycle strobe.
  - `mosi[7:0]`: output.
  - `miso[7:0]`: input, combinational from the responder and valid in the strobe cycle.
- mode_fault  in  1  responder request-to-send pulse.
- req_valid  in  1  command request.
- req_ready  out  1  accepting command; high only in IDLE with link up.
- req_opcode  in  8  command byte (0xB0 status, 0xA6 open, 0xA7 close).
- req_arg_len  in  2  number of 0x00 filler bytes after the opcode (0..3).
- rsp_valid  out  1  1-cycle pulse; response fields valid.
- rsp_ack_ok  out  1  miso in the opcode cycle was 0x55.
- rsp_data  out  24  filler-byte miso values, first byte in [23:16]; unused bytes 0.
- status_valid  out  1  1-cycle pulse; status fields updated.
- status_disc  out  8  disc byte (0x01 audio, 0x03 none, 0x04 CD-i).
- status_tray  out  8  tray byte (0x25 closed, 0x21 open).
- link_up  out  1  sync completed.
- error  out  1  sticky until reset; set on bad header or timeout.

## Operation
- **SYNC**: send 0xDD every BYTE_GAP+1 cycles. The cycle with miso==0xEE sets link_up and moves to IDLE.
- **IDLE**: a mode_fault pulse goes to STAT_READ. Otherwise, req_valid&&req_ready latches the opcode and length, then goes to CMD_SEND.
- **CMD_SEND**: strobe the opcode, then req_arg_len bytes of 0x00. Capture miso for every byte. After the last byte, pulse rsp_valid, then go to WAIT_FAULT.
- **WAIT_FAULT**: mode_fault goes to STAT_READ. If the timeout counter reaches STATUS_TIMEOUT, set error and go to IDLE.
- **STAT_READ**: strobe 0xAA five times.
  - Bytes 0..2 must be 0x03, 0xB0, 0x00. Any mismatch sets error, and no status_valid is produced.
  - Bytes 3 and 4 load status_disc and status_tray.
  - status_valid pulses in the cycle after byte 4, then the block returns to IDLE.
- mode_fault arriving outside IDLE/WAIT_FAULT is ignored. The responder re-raises it.

## Timing
- Reset values:
  - spi.write=0, spi.mosi=0xFF.
  - req_ready, rsp_valid, status_valid, link_up, error all 0.
  - rsp_data=0, status_disc=0x03, status_tray=0x25.
  - State is SYNC.
- First SYNC strobe: cycle BYTE_GAP+1 after reset deassertion.
- Strobe spacing: exactly BYTE_GAP+1 cycles within a sequence. The first strobe of CMD_SEND or STAT_READ comes BYTE_GAP+1 cycles after entry.
- spi.mosi is registered and stable in the strobe cycle. The byte is 0xFF when not strobing.
- rsp_valid fires one cycle after the last CMD_SEND strobe.
- The WAIT_FAULT counter starts at 0 on entry, and a timeout fires when it equals STATUS_TIMEOUT.
- Simultaneous mode_fault and req_valid in IDLE: the status read wins, and req_ready is low that cycle.
- Reset assertion mid-sequence: all outputs return to their reset values immediately. The block re-syncs from SYNC.
- Counter widths are $clog2(param+1). The byte index is 3 bits.

## Structure
- Package `servo_pkg`:
  - Constants SERVO_SYNC 0xDD, SERVO_SYNC_ACK 0xEE, SERVO_CMD_ACK 0x55, SERVO_POLL 0xAA, SERVO_HDR0 0x03, SERVO_HDR1 0xB0.
  - Opcode constants 0xB0/0xA6/0xA7.
  - Disc/tray byte constants.
  - State enum type.
- Sub-module `servo_byte_pacer`: BYTE_GAP down-counter with start/fire outputs, shared by all strobing states.

## Test plan
- Responder returns 0xFF for three 0xDD strobes, then 0xEE → link_up rises after the 4th strobe, and req_ready goes high.
- Request 0xB0 with arg_len=3; responder returns 55 61 01 01 → rsp_ack_ok=1, rsp_data=0x610101. Then mode_fault; frame 03 B0 00 04 25 → status_valid, disc=0x04, tray=0x25.
- Request 0xA6 with arg_len=3, then frame 03 B0 00 03 21 → status_disc=0x03, status_tray=0x21, error=0.
- Unsolicited mode_fault in IDLE with req_valid high the same cycle; frame 03 B0 00 01 25 → status read first, disc=0x01, command accepted afterward.
- Command with no mode_fault → error=1 after STATUS_TIMEOUT cycles, state IDLE. A frame 03 B1 00 04 25 → error=1, no status_valid.
- reset_n low during the 3rd STAT_READ strobe → outputs at reset values, and SYNC strobes resume.
